ldm_reg_writer: RTL and testbench
=================================

// Module: ldm_reg_writer
// PURPOSE
//  Write-side sequencer for the 16x32 register file: executes a load-multiple by walking a
//  16-bit register list lowest-index first, fetching one word per register over a req/ack
//  memory port and driving the file's write port (RW, PW, LE) once per loaded register.
//  R15 is the PC, not a file register: its word is routed to pc_load/pc_value instead.
//  Optional base-register writeback. Sits between the memory stage and Register_file.
// PARAMETERS
//  DW         32   data and address width
//  ADDR_STEP  4    byte increment between consecutive words
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  start      in   1   begin transfer; sampled only while busy=0
//  reg_list   in   16  register mask; bit i set = load Ri
//  base_addr  in   DW  address of first word
//  wb         in   1   write final address back to base_reg
//  base_reg   in   4   base register index
//  mem_req    out  1   memory read request
//  mem_addr   out  DW  read address, stable while mem_req=1 and mem_ack=0
//  mem_ack    in   1   read data valid this cycle; ignored when mem_req=0
//  mem_rdata  in   DW  read data, qualified by mem_ack
//  RW         out  4   register-file write index
//  PW         out  DW  register-file write data
//  LE         out  1   register-file write enable, one-cycle pulse per write
//  pc_load    out  1   one-cycle pulse: load PC with pc_value
//  pc_value   out  DW  new PC, mem_rdata with bits[1:0] cleared
//  busy       out  1   high whenever state != IDLE
//  done       out  1   one-cycle pulse, transfer complete
// BEHAVIOUR
//  - Reset: state=IDLE; mem_req, mem_addr, RW, PW, LE, pc_load, pc_value, busy, done all 0.
//    Reset mid-transfer aborts immediately; writes already issued stay, the rest are dropped.
//  - All outputs are registered except busy and done, which decode the state.
//  - States: IDLE, LOAD, WBASE, FIN.
//  - IDLE: start=1, reg_list!=0 -> latch list, wb, base_reg, base_addr; addr<=base_addr;
//    ->LOAD. start=1, reg_list==0 -> FIN (no reads, no writes). start while busy: ignored.
//  - LOAD: mem_req=1, mem_addr=addr. On an edge with mem_ack=1, i = lowest set bit of the
//    remaining list: i<15 -> LE<=1, RW<=i, PW<=mem_rdata; i==15 -> pc_load<=1,
//    pc_value<={mem_rdata[DW-1:2],2'b00}, LE<=0. Clear bit i; addr<=addr+ADDR_STEP.
//    The clearing edge of the last bit -> WBASE if wb=1 and reg_list[base_reg]=0, else FIN.
//    mem_req drops in the cycle after the last ack.
//  - mem_ack=0: hold mem_req, mem_addr and list; LE=0; no limit on wait cycles.
//  - WBASE: leaving edge sets LE<=1, RW<=base_reg, PW<=base_addr+ADDR_STEP*popcount(list);
//    ->FIN. A base_reg in the list takes the loaded value; no writeback.
//  - FIN: done=1 for one cycle; ->IDLE. LE and pc_load return to 0 after each pulse.
//  - Timing with N regs acked at cycles 1..N after start at cycle 0: LE pulses at 2..N+1;
//    done at N+1, or N+2 with writeback (WB pulse also at N+2).
//  - Address arithmetic wraps modulo 2^DW.
// TESTING
//  1. rst=1 mid-run, any inputs -> every output 0 same cycle; start after release works.
//  2. list=16'h0006, base=0x100, ack every cycle, rdata 0xAAAA0001,0xAAAA0002 -> mem_addr
//     0x100,0x104; LE RW=1 PW=0xAAAA0001 cycle 2, RW=2 PW=0xAAAA0002 cycle 3; done cycle 3.
//  3. list=16'h8001, rdata 0x11 then 0x207 -> LE RW=0 PW=0x11; pc_load=1 pc_value=0x204
//     with LE=0; no write to index 15.
//  4. list=16'h0070, base=0x200, wb=1, base_reg=13 -> writes R4,R5,R6 then LE RW=13 PW=0x20C,
//     done with it. Repeat list=16'h2010 -> R13 takes loaded data, no writeback pulse.
//  5. mem_ack low 3 cycles on 2nd word -> mem_req=1, mem_addr=base+4 held, LE=0 throughout.
//  6. list=0 -> done cycle 1, no mem_req/LE; start during busy -> ignored, mask unchanged.

Source files
------------

// File: rtl/ldm_reg_writer.sv
// ldm_reg_writer
//   Write-side sequencer for the 16x32 register file. Executes a load-multiple:
//   walks reg_list lowest index first, fetches one word per set bit over a
//   req/ack memory port, and writes each word through the file's write port
//   (RW/PW/LE). R15 is the PC, so its word goes to pc_load/pc_value instead.
//   Optionally writes the final address back to the base register.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin transfer; sampled only while busy=0
//   reg_list          register mask, bit i set = load Ri
//   base_addr         address of the first word
//   wb, base_reg      write final address back to base_reg
//   mem_req/mem_addr  memory read request and address
//   mem_ack/mem_rdata read data valid / read data
//   RW, PW, LE        register-file write index, data, enable (pulse)
//   pc_load, pc_value PC load pulse and word-aligned value
//   busy              high whenever not idle
//   done              one-cycle pulse when the transfer completes
module ldm_reg_writer #(
  parameter int unsigned DW        = 32,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   reg_list,
  input  logic [DW-1:0] base_addr,
  input  logic          wb,
  input  logic [3:0]    base_reg,
  output logic          mem_req,
  output logic [DW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [3:0]    RW,
  output logic [DW-1:0] PW,
  output logic          LE,
  output logic          pc_load,
  output logic [DW-1:0] pc_value,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WBASE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [DW-1:0] STEP = DW'(ADDR_STEP);

  state_t      state;
  logic [15:0] remaining;
  logic        wb_pending;
  logic [3:0]  wb_reg;
  logic [3:0]  low_idx;
  logic        last_bit;

  // Lowest set bit of the registers still to load.
  always_comb begin
    low_idx = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (remaining[15 - k]) low_idx = 4'(15 - k);
    end
  end

  assign last_bit = ((remaining & (remaining - 16'd1)) == '0);

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      wb_pending <= 1'b0;
      wb_reg     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      RW         <= '0;
      PW         <= '0;
      LE         <= 1'b0;
      pc_load    <= 1'b0;
      pc_value   <= '0;
    end else begin
      LE      <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (reg_list != '0) begin
              remaining  <= reg_list;
              // Writeback is suppressed when the base register is itself loaded.
              wb_pending <= wb & ~reg_list[base_reg];
              wb_reg     <= base_reg;
              mem_addr   <= base_addr;
              mem_req    <= 1'b1;
              state      <= LOAD;
            end else begin
              state <= FIN;
            end
          end
        end
        LOAD: begin
          if (mem_ack) begin
            if (low_idx != 4'd15) begin
              LE <= 1'b1;
              RW <= low_idx;
              PW <= mem_rdata;
            end else begin
              pc_load  <= 1'b1;
              pc_value <= {mem_rdata[DW-1:2], 2'b00};
            end
            remaining[low_idx] <= 1'b0;
            mem_addr           <= mem_addr + STEP;
            if (last_bit) begin
              mem_req <= 1'b0;
              state   <= wb_pending ? WBASE : FIN;
            end
          end
        end
        WBASE: begin
          // mem_addr has advanced once per loaded word, so it already equals
          // base_addr + ADDR_STEP * popcount(reg_list).
          LE    <= 1'b1;
          RW    <= wb_reg;
          PW    <= mem_addr;
          state <= FIN;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_reg_writer.sv
module tb_ldm_reg_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] reg_list = '0;
  logic [31:0] base_addr = '0;
  logic        wb = 1'b0;
  logic [3:0]  base_reg = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  RW;
  logic [31:0] PW;
  logic        LE;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        busy;
  logic        done;

  ldm_reg_writer #(.DW(32), .ADDR_STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_list(reg_list),
    .base_addr(base_addr), .wb(wb), .base_reg(base_reg),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .RW(RW), .PW(PW), .LE(LE), .pc_load(pc_load),
    .pc_value(pc_value), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          k;
  } rd_t;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } wr_t;

  rd_t         mem_q[$];
  wr_t         exp_wr[$];
  logic [31:0] exp_pc[$];
  int          exp_done = 0;

  int n_cmp = 0;
  int n_err = 0;

  int          ack_pct = 100;
  int          stall_word = -1;
  int          stall_left = 0;
  logic [31:0] fix_d[16];
  bit          use_fix = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred that the model does not allow", name);
  endtask

  // Memory responder: checks the address against the model and answers with
  // the model's data; randomly acks while mem_req is low to show it is ignored.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (mem_q.size() == 0) begin
          note_fail("req_unexpected");
          mem_ack = 1'b0;
        end else begin
          chk32("mem_addr", mem_addr, mem_q[0].addr);
          if (mem_q[0].k == stall_word && stall_left > 0) begin
            stall_left--;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
          end else if (int'($urandom_range(99)) < ack_pct) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_q[0].data;
            void'(mem_q.pop_front());
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
          end
        end
      end else begin
        mem_ack   = 1'($urandom_range(1));
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every write, PC load and done is popped against the scoreboard.
  initial begin : monitor
    wr_t         w;
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (LE) begin
          if (exp_wr.size() == 0) note_fail("le_unexpected");
          else begin
            w = exp_wr.pop_front();
            chk32("RW", 32'(RW), 32'(w.idx));
            chk32("PW", PW, w.data);
          end
        end
        if (pc_load) begin
          if (exp_pc.size() == 0) note_fail("pc_unexpected");
          else begin
            p = exp_pc.pop_front();
            chk32("pc_value", pc_value, p);
          end
          chk32("le_with_pc_load", 32'(LE), 32'd0);
        end
        if (done) begin
          if (exp_done == 0) note_fail("done_unexpected");
          else exp_done--;
          chk32("writes_left_at_done", 32'(exp_wr.size()), 32'd0);
          chk32("pc_left_at_done", 32'(exp_pc.size()), 32'd0);
          chk32("reads_left_at_done", 32'(mem_q.size()), 32'd0);
        end
      end
    end
  end

  // Builds the expected transaction from the list: the k-th set bit (ascending)
  // is read from base + 4k; a writeback lands at base + 4*count.
  task automatic issue_start(input logic [15:0] list, input logic [31:0] base,
                             input logic w, input logic [3:0] breg,
                             output int n, output bit wbx);
    logic [31:0] d;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        d = use_fix ? fix_d[n] : $urandom;
        mem_q.push_back('{base + 32'(4 * n), d, n});
        if (i < 15) exp_wr.push_back('{4'(i), d});
        else exp_pc.push_back({d[31:2], 2'b00});
        n++;
      end
    end
    wbx = w && (list != 16'h0) && !list[breg];
    if (wbx) exp_wr.push_back('{breg, base + 32'(4 * n)});
    exp_done++;
    start     = 1'b1;
    reg_list  = list;
    base_addr = base;
    wb        = w;
    base_reg  = breg;
    @(posedge clk);
  endtask

  // Waits for done while pushing junk starts that a busy DUT must ignore.
  task automatic wait_done(input int lat, input bit check_lat);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt <= 500) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        start     = 1'($urandom_range(1));
        reg_list  = 16'($urandom);
        base_addr = $urandom;
        wb        = 1'($urandom_range(1));
        base_reg  = 4'($urandom);
        cnt++;
      end
    end
    start = 1'b0;
    if (!seen) note_fail("done_timeout");
    else if (check_lat) chk32("done_latency", 32'(cnt), 32'(lat));
  endtask

  task automatic run_txn(input logic [15:0] list, input logic [31:0] base,
                         input logic w, input logic [3:0] breg);
    int n;
    bit wbx;
    bit chk;
    chk = (ack_pct == 100) && (stall_left == 0);
    issue_start(list, base, w, breg, n, wbx);
    wait_done(n + (wbx ? 1 : 0), chk);
    stall_word = -1;
    stall_left = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk32({tag, "_mem_req"},  32'(mem_req), 32'd0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk32({tag, "_RW"},       32'(RW), 32'd0);
    chk32({tag, "_PW"},       PW, 32'd0);
    chk32({tag, "_LE"},       32'(LE), 32'd0);
    chk32({tag, "_pc_load"},  32'(pc_load), 32'd0);
    chk32({tag, "_pc_value"}, pc_value, 32'd0);
    chk32({tag, "_busy"},     32'(busy), 32'd0);
    chk32({tag, "_done"},     32'(done), 32'd0);
  endtask

  initial begin : stimulus
    int          n;
    bit          wbx;
    logic [15:0] l;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Two loads, back-to-back acks.
    use_fix  = 1'b1;
    fix_d[0] = 32'hAAAA_0001;
    fix_d[1] = 32'hAAAA_0002;
    run_txn(16'h0006, 32'h0000_0100, 1'b0, 4'd0);

    // R0 then PC.
    fix_d[0] = 32'h0000_0011;
    fix_d[1] = 32'h0000_0207;
    run_txn(16'h8001, 32'h0000_0040, 1'b0, 4'd0);

    // Writeback, then base register inside the list.
    use_fix = 1'b0;
    run_txn(16'h0070, 32'h0000_0200, 1'b1, 4'd13);
    run_txn(16'h2010, 32'h0000_0200, 1'b1, 4'd13);

    // Three-cycle stall on the second word.
    stall_word = 1;
    stall_left = 3;
    run_txn(16'h00F0, 32'h0000_0300, 1'b0, 4'd0);

    // Empty list, address wrap, PC plus writeback.
    run_txn(16'h0000, 32'h0000_0400, 1'b1, 4'd2);
    run_txn(16'h000F, 32'hFFFF_FFF8, 1'b1, 4'd7);
    run_txn(16'h8000, 32'h0000_0500, 1'b1, 4'd15);
    run_txn(16'h8100, 32'h0000_0600, 1'b1, 4'd1);

    // Reset in the middle of a full-list transfer.
    issue_start(16'hFFFF, 32'h0000_1000, 1'b1, 4'd3, n, wbx);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    mem_q.delete();
    exp_wr.delete();
    exp_pc.delete();
    exp_done = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_txn(16'h0003, 32'h0000_0800, 1'b1, 4'd9);

    // Randomised transfers.
    repeat (40) begin
      ack_pct = ($urandom_range(1) == 1) ? 100 : int'($urandom_range(90, 30));
      l = ($urandom_range(7) == 0) ? 16'h0000 : 16'($urandom);
      run_txn(l, $urandom, 1'($urandom_range(1)), 4'($urandom));
    end
    ack_pct = 100;

    repeat (3) @(negedge clk);
    chk32("final_reads_left", 32'(mem_q.size()), 32'd0);
    chk32("final_writes_left", 32'(exp_wr.size()), 32'd0);
    chk32("final_done_left", 32'(exp_done), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
